// File: rtl/s_term_loopback_pipe.sv
// s_term_loopback_pipe: bottom-row tile looping from_S back to to_N with per-channel
// register bypass, config capture from FrameData and a pipelined frame-strobe path.
module s_term_loopback_pipe #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NUM_WIRES       = 12,
  parameter int STROBE_PIPE     = 1,
  parameter int CFG_FRAME       = 0
) (
  input  logic                       UserCLK,
  input  logic                       rst,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic [NUM_WIRES-1:0]       from_S,
  output logic [NUM_WIRES-1:0]       to_N,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       UserCLKo,
  output logic                       rsto,
  output logic                       cfg_loaded
);
  generate
    if (NUM_WIRES < 1 || NUM_WIRES > FrameBitsPerRow) begin : g_err_wires
      $error("NUM_WIRES must be in 1..FrameBitsPerRow");
    end
    if (CFG_FRAME < 0 || CFG_FRAME >= MaxFramesPerCol) begin : g_err_frame
      $error("CFG_FRAME must index a FrameStrobe bit");
    end
    if (STROBE_PIPE < 0 || STROBE_PIPE > 3) begin : g_err_pipe
      $error("STROBE_PIPE must be in 0..3");
    end
  endgenerate
  logic [NUM_WIRES-1:0] cfg_q, cfg_d, wire_q, wire_d;
  logic                 strobe_q, strobe_d, loaded_q, loaded_d, capture;
  logic                 unused_frame_data;
  assign unused_frame_data = ^FrameData;
  // Rising edge of the config strobe: a held strobe captures only once.
  assign capture = FrameStrobe[CFG_FRAME] & ~strobe_q;
  always_comb begin
    strobe_d = FrameStrobe[CFG_FRAME];
    cfg_d    = capture ? FrameData[NUM_WIRES-1:0] : cfg_q;
    loaded_d = loaded_q | capture;
    wire_d   = from_S;
  end
  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      cfg_q    <= '0;
      wire_q   <= '0;
      strobe_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      wire_q   <= wire_d;
      strobe_q <= strobe_d;
      loaded_q <= loaded_d;
    end
  end
  assign to_N       = (cfg_q & wire_q) | (~cfg_q & from_S);
  assign cfg_loaded = loaded_q;
  assign UserCLKo   = UserCLK;
  assign rsto       = rst;
  generate
    if (STROBE_PIPE == 0) begin : g_strobe_comb
      assign FrameStrobe_O = FrameStrobe;
    end else begin : g_strobe_pipe
      logic [MaxFramesPerCol-1:0] pipe_q [STROBE_PIPE];
      logic [MaxFramesPerCol-1:0] pipe_d [STROBE_PIPE];
      always_comb begin
        pipe_d[0] = FrameStrobe;
        for (int k = 1; k < STROBE_PIPE; k++) pipe_d[k] = pipe_q[k-1];
      end
      always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) pipe_q <= '{default: '0};
        else pipe_q <= pipe_d;
      end
      assign FrameStrobe_O = pipe_q[STROBE_PIPE-1];
    end
  endgenerate
endmodule

// File: tb/tb_s_term_loopback_pipe.sv
// tb_s_term_loopback_pipe: randomized scenarios against a cycle-level behavioural model
// of channel latency, config capture and strobe delay (STROBE_PIPE=2 build).
module tb_s_term_loopback_pipe;
  localparam int MF = 20, FB = 32, NW = 12, SP = 2;
  logic          clk = 1'b0, rst = 1'b0;
  logic [FB-1:0] frame_data = '0;
  logic [MF-1:0] frame_strobe = '0;
  logic [NW-1:0] from_s = '0;
  logic [NW-1:0] to_n;
  logic [MF-1:0] strobe_o;
  logic          clk_o, rst_o, loaded;
  int            n_tests = 0, n_fail = 0;
  logic [NW-1:0] m_cfg, m_last_from;
  logic          m_loaded, m_prev_sb;
  logic [MF-1:0] m_hist [SP];
  s_term_loopback_pipe #(.MaxFramesPerCol(MF), .FrameBitsPerRow(FB), .NUM_WIRES(NW),
                         .STROBE_PIPE(SP), .CFG_FRAME(0)) dut (
    .UserCLK(clk), .rst(rst), .FrameData(frame_data), .FrameStrobe(frame_strobe),
    .from_S(from_s), .to_N(to_n), .FrameStrobe_O(strobe_o), .UserCLKo(clk_o),
    .rsto(rst_o), .cfg_loaded(loaded));
  always #5 clk = ~clk;
  function automatic logic [NW-1:0] exp_to_n();
    logic [NW-1:0] r;
    for (int i = 0; i < NW; i++) r[i] = m_cfg[i] ? m_last_from[i] : from_s[i];
    return r;
  endfunction
  task automatic model_clear();
    m_cfg = '0; m_last_from = '0; m_loaded = 1'b0; m_prev_sb = 1'b0;
    for (int k = 0; k < SP; k++) m_hist[k] = '0;
  endtask
  // Advance one clock edge, update the model with the inputs seen at that edge, settle.
  task automatic step();
    @(posedge clk);
    if (rst) model_clear();
    else begin
      if (frame_strobe[0] && !m_prev_sb) begin
        m_cfg = frame_data[NW-1:0];
        m_loaded = 1'b1;
      end
      m_prev_sb = frame_strobe[0];
      m_last_from = from_s;
      for (int k = 0; k < SP-1; k++) m_hist[k] = m_hist[k+1];
      m_hist[SP-1] = frame_strobe;
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; model_clear();
    from_s = 12'hA5C; frame_strobe = '0;
    #1;
    n_tests++;
    if (to_n !== 12'hA5C) begin n_fail++; $display("FAIL reset_to_n got %h exp %h", to_n, 12'hA5C); end
    n_tests++;
    if (loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded got %b exp 0", loaded); end
    n_tests++;
    if (rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_rsto got %b exp 1", rst_o); end
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < SP; c++) begin
      frame_strobe = MF'($urandom) & ~MF'(1);
      from_s = NW'($urandom);
      #1;
      n_tests++;
      if (strobe_o !== '0) begin n_fail++; $display("FAIL post_reset_strobe_o cyc %0d got %h exp 0", c, strobe_o); end
      n_tests++;
      if (to_n !== from_s) begin n_fail++; $display("FAIL post_reset_to_n got %h exp %h", to_n, from_s); end
      step();
    end
    frame_strobe = '0;
  endtask
  task automatic test_config_pulse();
    frame_data = 32'h0000_0F0F; frame_strobe = 20'h00001;
    step();
    frame_strobe = '0; frame_data = $urandom;
    for (int c = 0; c < 10; c++) begin
      from_s = NW'($urandom);
      #1;
      n_tests++;
      if (loaded !== 1'b1) begin n_fail++; $display("FAIL pulse_loaded got %b exp 1", loaded); end
      n_tests++;
      if (to_n !== exp_to_n()) begin n_fail++; $display("FAIL pulse_to_n got %h exp %h", to_n, exp_to_n()); end
      step();
    end
  endtask
  task automatic test_hold();
    logic [NW-1:0] first;
    frame_strobe = '0; step();
    for (int c = 0; c < 5; c++) begin
      frame_data = $urandom; frame_strobe = 20'h00001;
      if (c == 0) first = frame_data[NW-1:0];
      from_s = NW'($urandom);
      step();
    end
    frame_strobe = '0;
    n_tests++;
    if (m_cfg !== first) begin n_fail++; $display("FAIL hold_model_cfg got %h exp %h", m_cfg, first); end
    for (int c = 0; c < 8; c++) begin
      from_s = NW'($urandom);
      #1;
      n_tests++;
      if (to_n !== exp_to_n()) begin n_fail++; $display("FAIL hold_to_n got %h exp %h", to_n, exp_to_n()); end
      step();
    end
  endtask
  task automatic test_strobe_pipe();
    int seen_at = -1, seen_n = 0;
    frame_strobe = 20'h00010;
    #1;
    step();
    frame_strobe = '0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (strobe_o === 20'h00010) begin seen_n++; if (seen_at < 0) seen_at = c; end
      n_tests++;
      if (strobe_o !== m_hist[0]) begin n_fail++; $display("FAIL pipe_strobe_o cyc %0d got %h exp %h", c, strobe_o, m_hist[0]); end
      step();
    end
    n_tests++;
    if (seen_at != SP || seen_n != 1) begin
      n_fail++; $display("FAIL pipe_pulse_timing got at=%0d n=%0d exp at=%0d n=1", seen_at, seen_n, SP);
    end
    for (int c = 0; c < 30; c++) begin
      frame_strobe = MF'($urandom) & ~MF'(1);
      #1;
      n_tests++;
      if (strobe_o !== m_hist[0]) begin n_fail++; $display("FAIL pipe_rand_strobe_o got %h exp %h", strobe_o, m_hist[0]); end
      step();
    end
    frame_strobe = '0;
  endtask
  task automatic test_reset_mid();
    frame_strobe = '0; step();
    frame_data = 32'h0000_0FFF; frame_strobe = 20'h00001; step();
    from_s = NW'($urandom); step();
    from_s = ~from_s;
    #1;
    n_tests++;
    if (to_n !== ~from_s) begin n_fail++; $display("FAIL mid_pre_to_n got %h exp %h", to_n, ~from_s); end
    rst = 1'b1; model_clear();
    #1;
    n_tests++;
    if (to_n !== from_s) begin n_fail++; $display("FAIL mid_rst_to_n got %h exp %h", to_n, from_s); end
    n_tests++;
    if (loaded !== 1'b0) begin n_fail++; $display("FAIL mid_rst_loaded got %b exp 0", loaded); end
    step();
    rst = 1'b0; frame_data = 32'h0000_0C35;
    step();
    frame_data = $urandom;
    for (int c = 0; c < 4; c++) begin
      from_s = NW'($urandom);
      #1;
      n_tests++;
      if (loaded !== 1'b1) begin n_fail++; $display("FAIL mid_recap_loaded got %b exp 1", loaded); end
      n_tests++;
      if (to_n !== exp_to_n()) begin n_fail++; $display("FAIL mid_recap_to_n got %h exp %h", to_n, exp_to_n()); end
      step();
    end
    frame_strobe = '0; step();
  endtask
  task automatic test_reconfig_zero();
    frame_data = 32'h0000_0FFF; frame_strobe = 20'h00001; step();
    frame_strobe = '0; step();
    frame_data = '0; frame_strobe = 20'h00001; step();
    frame_strobe = '0; frame_data = $urandom;
    for (int c = 0; c < 6; c++) begin
      from_s = NW'($urandom);
      #1;
      n_tests++;
      if (to_n !== from_s) begin n_fail++; $display("FAIL zero_to_n got %h exp %h", to_n, from_s); end
      n_tests++;
      if (loaded !== 1'b1) begin n_fail++; $display("FAIL zero_loaded got %b exp 1", loaded); end
      step();
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      frame_data = $urandom;
      frame_strobe = MF'($urandom) & ~MF'(1);
      frame_strobe[0] = ($urandom_range(3) == 0);
      from_s = NW'($urandom);
      #1;
      n_tests++;
      if (to_n !== exp_to_n()) begin n_fail++; $display("FAIL rand_to_n cyc %0d got %h exp %h", c, to_n, exp_to_n()); end
      n_tests++;
      if (strobe_o !== m_hist[0]) begin n_fail++; $display("FAIL rand_strobe_o cyc %0d got %h exp %h", c, strobe_o, m_hist[0]); end
      n_tests++;
      if (loaded !== m_loaded) begin n_fail++; $display("FAIL rand_loaded cyc %0d got %b exp %b", c, loaded, m_loaded); end
      n_tests++;
      if (clk_o !== clk) begin n_fail++; $display("FAIL rand_clk_o got %b exp %b", clk_o, clk); end
      step();
    end
  endtask
  initial begin
    test_reset();
    test_config_pulse();
    test_hold();
    test_strobe_pipe();
    test_reset_mid();
    test_reconfig_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
